// File: rtl/window_seq_ctrl_pkg.sv
// Shared definitions for the sliding-window sequencer.
//   state_t : sequencer states (IDLE waits for a start of frame, FILL primes
//             the shift register, RUN presents in-frame windows)
//   clog2   : counter width helper, never returns less than 1
package win_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      FILL = 2'd1,
      RUN  = 2'd2
   } state_t;

   // XW = clog2(frameW), YW = clog2(frameH); a width of 0 is never returned
   function automatic int unsigned clog2(input int unsigned v);
      int unsigned r;
      r = 0;
      while ((64'd1 << r) < 64'(v)) r++;
      if (r == 0) r = 1;
      return r;
   endfunction

endpackage

// File: rtl/window_seq_ctrl_if.sv
// Pixel-in / window-out bus of window_seq_ctrl.
//   master : pixel source + window consumer side (drives in_valid, in_sof,
//            in_data, out_ready)
//   slave  : sequencer side (drives in_ready, sr_ce, sr_data, win_valid,
//            win_x, win_y, frame_done, sof_err)
interface window_seq_ctrl_if
   import win_pkg::*;
#(
   parameter int unsigned dataDept = 8,
   parameter int unsigned frameW   = 640,
   parameter int unsigned frameH   = 480
);
   localparam int unsigned XW = clog2(frameW);
   localparam int unsigned YW = clog2(frameH);

   logic                in_valid;
   logic                in_sof;
   logic [dataDept-1:0] in_data;
   logic                in_ready;
   logic                sr_ce;
   logic [dataDept-1:0] sr_data;
   logic                win_valid;
   logic                out_ready;
   logic [XW-1:0]       win_x;
   logic [YW-1:0]       win_y;
   logic                frame_done;
   logic                sof_err;

   modport master (
      output in_valid, in_sof, in_data, out_ready,
      input  in_ready, sr_ce, sr_data, win_valid, win_x, win_y, frame_done, sof_err
   );

   modport slave (
      input  in_valid, in_sof, in_data, out_ready,
      output in_ready, sr_ce, sr_data, win_valid, win_x, win_y, frame_done, sof_err
   );
endinterface

// File: rtl/window_seq_ctrl_raster_pos_cnt.sv
// Raster position counter.
//   clk, rst_n  : clock, asynchronous active-low reset
//   en_i        : a pixel enters the shift register this cycle
//   clr_i       : that pixel is (0,0) of a new frame
//   x_o, y_o    : coordinates of the pixel presented this cycle
//   last_col_o  : that pixel is the last of its line
//   last_pix_o  : that pixel is the last of the frame
// The registers hold the position the next pixel will take; x_o/y_o fold in
// clr_i so the caller sees the true coordinate of the current pixel.
module raster_pos_cnt
   import win_pkg::*;
#(
   parameter int unsigned frameW = 640,
   parameter int unsigned frameH = 480,
   parameter int unsigned XW     = clog2(frameW),
   parameter int unsigned YW     = clog2(frameH)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          en_i,
   input  logic          clr_i,
   output logic [XW-1:0] x_o,
   output logic [YW-1:0] y_o,
   output logic          last_col_o,
   output logic          last_pix_o
);
   localparam logic [XW-1:0] XLAST = XW'(frameW - 1);
   localparam logic [YW-1:0] YLAST = YW'(frameH - 1);

   logic [XW-1:0] x_q, x_d;
   logic [YW-1:0] y_q, y_d;

   always_comb begin
      x_o        = clr_i ? '0 : x_q;
      y_o        = clr_i ? '0 : y_q;
      last_col_o = (x_o == XLAST);
      last_pix_o = last_col_o & (y_o == YLAST);
      x_d        = x_q;
      y_d        = y_q;
      if (en_i) begin
         if (last_col_o) begin
            x_d = '0;
            y_d = last_pix_o ? '0 : y_o + YW'(1);
         end else begin
            x_d = x_o + XW'(1);
            y_d = y_o;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         x_q <= '0;
         y_q <= '0;
      end else begin
         x_q <= x_d;
         y_q <= y_d;
      end
   end
endmodule

// File: rtl/window_seq_ctrl.sv
// Sliding-window sequencer.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : window_seq_ctrl_if.slave
//     in_valid/in_sof/in_data/in_ready : pixel input handshake
//     sr_ce/sr_data                    : shift-register enable and data
//     win_valid/out_ready              : window output handshake
//     win_x/win_y                      : newest pixel of the presented window
//     frame_done/sof_err               : one-cycle status pulses
module window_seq_ctrl
   import win_pkg::*;
#(
   parameter int unsigned dataDept = 8,
   parameter int unsigned frameW   = 640,
   parameter int unsigned frameH   = 480,
   parameter int unsigned windowW  = 3,
   parameter int unsigned windowH  = 3
) (
   input  logic             clk,
   input  logic             rst_n,
   window_seq_ctrl_if.slave bus
);
   localparam int unsigned   XW     = clog2(frameW);
   localparam int unsigned   YW     = clog2(frameH);
   localparam logic [XW-1:0] WX_MIN = XW'(windowW - 1);
   localparam logic [YW-1:0] WY_MIN = YW'(windowH - 1);

   state_t        state_q, state_d;
   logic          win_valid_q, win_valid_d;
   logic [XW-1:0] win_x_q, win_x_d;
   logic [YW-1:0] win_y_q, win_y_d;
   logic          frame_done_q, frame_done_d;
   logic          sof_err_q, sof_err_d;

   logic          in_ready, accept, sr_ce, qual, first_win;
   logic [XW-1:0] pix_x;
   logic [YW-1:0] pix_y;
   logic          last_col, last_pix;

   assign in_ready = ~win_valid_q | bus.out_ready;
   assign accept   = bus.in_valid & in_ready;
   assign sr_ce    = accept & ((state_q != IDLE) | bus.in_sof);

   raster_pos_cnt #(
      .frameW (frameW),
      .frameH (frameH),
      .XW     (XW),
      .YW     (YW)
   ) u_pos (
      .clk        (clk),
      .rst_n      (rst_n),
      .en_i       (sr_ce),
      .clr_i      (bus.in_sof),
      .x_o        (pix_x),
      .y_o        (pix_y),
      .last_col_o (last_col),
      .last_pix_o (last_pix)
   );

   assign qual      = (pix_x >= WX_MIN) & (pix_y >= WY_MIN);
   assign first_win = (pix_x == WX_MIN) & (pix_y == WY_MIN);

   always_comb begin
      state_d      = state_q;
      frame_done_d = 1'b0;
      sof_err_d    = 1'b0;
      if (sr_ce) begin
         if (bus.in_sof) begin
            state_d   = FILL;
            sof_err_d = (state_q != IDLE);
         end else begin
            // A window as large as the frame makes the first window the last pixel.
            case (state_q)
               FILL: begin
                  if (last_pix) state_d = IDLE;
                  else if (first_win) state_d = RUN;
               end
               RUN: if (last_pix) state_d = IDLE;
               default: state_d = IDLE;
            endcase
            frame_done_d = last_pix;
         end
      end
   end

   // A dropped IDLE pixel with out_ready still consumes the held window.
   always_comb begin
      win_valid_d = win_valid_q;
      win_x_d     = win_x_q;
      win_y_d     = win_y_q;
      if (sr_ce) begin
         win_valid_d = qual;
         win_x_d     = pix_x;
         win_y_d     = pix_y;
      end else if (bus.out_ready) begin
         win_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         win_valid_q  <= 1'b0;
         win_x_q      <= '0;
         win_y_q      <= '0;
         frame_done_q <= 1'b0;
         sof_err_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         win_valid_q  <= win_valid_d;
         win_x_q      <= win_x_d;
         win_y_q      <= win_y_d;
         frame_done_q <= frame_done_d;
         sof_err_q    <= sof_err_d;
      end
   end

   assign bus.in_ready   = in_ready;
   assign bus.sr_ce      = sr_ce;
   assign bus.sr_data    = bus.in_data;
   assign bus.win_valid  = win_valid_q;
   assign bus.win_x      = win_x_q;
   assign bus.win_y      = win_y_q;
   assign bus.frame_done = frame_done_q;
   assign bus.sof_err    = sof_err_q;
endmodule

// File: tb/tb_window_seq_ctrl.sv
module tb_window_seq_ctrl;
   localparam int W  = 8;
   localparam int H  = 4;
   localparam int WW = 3;
   localparam int WH = 3;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   window_seq_ctrl_if #(.dataDept(8), .frameW(W), .frameH(H)) bus ();

   window_seq_ctrl #(
      .dataDept (8),
      .frameW   (W),
      .frameH   (H),
      .windowW  (WW),
      .windowH  (WH)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   typedef struct {int x; int y;} win_t;
   win_t sb_q[$];
   win_t log_a[$];
   win_t log_b[$];
   int   logsel = 0;
   int   n_win  = 0;
   int   checks = 0;
   int   errors = 0;

   // reference model: frame tracked as a linear pixel index
   bit m_active = 0;
   int m_idx    = 0;
   bit m_wv     = 0;
   int m_wx     = 0;
   int m_wy     = 0;
   bit m_fd     = 0;
   bit m_se     = 0;
   bit last_acc = 0;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic step(input bit v, input bit s, input bit ordy);
      bit exp_rdy, acc, taken, nfd, nse;
      int px, py;
      logic [7:0] d;
      @(negedge clk);
      d            = 8'($urandom_range(0, 255));
      bus.in_valid  = v;
      bus.in_sof    = s;
      bus.in_data   = d;
      bus.out_ready = ordy;
      #1;
      exp_rdy = !m_wv || ordy;
      acc     = v && exp_rdy;
      taken   = acc && (s || m_active);
      chk("in_ready", int'(bus.in_ready), int'(exp_rdy));
      chk("sr_ce", int'(bus.sr_ce), int'(taken));
      chk("sr_data", int'(bus.sr_data), int'(d));
      chk("win_valid", int'(bus.win_valid), int'(m_wv));
      if (m_wv) begin
         chk("win_x_hold", int'(bus.win_x), m_wx);
         chk("win_y_hold", int'(bus.win_y), m_wy);
      end
      chk("frame_done", int'(bus.frame_done), int'(m_fd));
      chk("sof_err", int'(bus.sof_err), int'(m_se));
      nfd = 0;
      nse = 0;
      if (taken) begin
         if (s) begin
            nse      = m_active;
            m_active = 1;
            m_idx    = 0;
         end else begin
            m_idx++;
         end
         px   = m_idx % W;
         py   = m_idx / W;
         m_wv = (px >= WW - 1) && (py >= WH - 1);
         m_wx = px;
         m_wy = py;
         if (m_wv) sb_q.push_back('{px, py});
         if (m_idx == W * H - 1) begin
            m_active = 0;
            nfd      = 1;
         end
      end else if (ordy) begin
         m_wv = 0;
      end
      m_fd     = nfd;
      m_se     = nse;
      last_acc = acc;
   endtask

   task automatic run_pix(input int n, input bit sof_first, input bit vtog, input bit orand);
      int cnt, guard;
      bit v;
      cnt   = 0;
      guard = 0;
      while (cnt < n && guard < 1000) begin
         v = vtog ? (guard % 2 == 0) : 1'b1;
         step(v, sof_first && cnt == 0 && v, orand ? 1'($urandom_range(0, 1)) : 1'b1);
         if (last_acc && v) cnt++;
         guard++;
      end
      if (guard >= 1000) chk("run_pix_timeout", cnt, n);
   endtask

   task automatic drain();
      for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b1);
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_in_ready"}, int'(bus.in_ready), 1);
      chk({tag, "_win_valid"}, int'(bus.win_valid), 0);
      chk({tag, "_win_x"}, int'(bus.win_x), 0);
      chk({tag, "_win_y"}, int'(bus.win_y), 0);
      chk({tag, "_frame_done"}, int'(bus.frame_done), 0);
      chk({tag, "_sof_err"}, int'(bus.sof_err), 0);
      chk({tag, "_sr_ce"}, int'(bus.sr_ce), 0);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n        = 1'b0;
      bus.in_valid = 1'b0;
      bus.in_sof   = 1'b0;
      #1;
      check_reset_outputs("rst_mid");
      m_active = 0;
      m_idx    = 0;
      m_wv     = 0;
      m_fd     = 0;
      m_se     = 0;
      sb_q.delete();
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   // scoreboard monitor: a window is consumed on the edge after win_valid&out_ready
   initial begin
      win_t e;
      forever begin
         @(negedge clk);
         #2;
         if (rst_n === 1'b1 && bus.win_valid === 1'b1 && bus.out_ready === 1'b1) begin
            if (sb_q.size() == 0) begin
               chk("sb_unexpected_window", 1, 0);
            end else begin
               e = sb_q.pop_front();
               chk("sb_win_x", int'(bus.win_x), e.x);
               chk("sb_win_y", int'(bus.win_y), e.y);
               n_win++;
               if (logsel == 1) log_a.push_back(e);
               if (logsel == 2) log_b.push_back(e);
            end
         end
      end
   end

   initial begin
      int n0, hold;
      bit held;
      rst_n         = 1'b0;
      bus.in_valid  = 1'b0;
      bus.in_sof    = 1'b0;
      bus.in_data   = '0;
      bus.out_ready = 1'b1;
      #1;
      check_reset_outputs("rst_init");
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;

      // 1: one full frame back-to-back
      n0     = n_win;
      logsel = 1;
      run_pix(32, 1'b1, 1'b0, 1'b0);
      drain();
      logsel = 0;
      chk("t1_windows", n_win - n0, 12);

      // 2: consumer stalls 5 cycles on the first window
      n0   = n_win;
      hold = 0;
      held = 0;
      begin
         int cnt = 0;
         int guard = 0;
         while (cnt < 32 && guard < 1000) begin
            bit ordy;
            ordy = 1'b1;
            if (m_wv && !held) begin
               ordy = 1'b0;
               hold++;
               if (hold == 5) held = 1;
            end
            step(1'b1, cnt == 0, ordy);
            if (!ordy) begin
               chk("t2_hold_x", int'(bus.win_x), 2);
               chk("t2_hold_y", int'(bus.win_y), 2);
               chk("t2_hold_ready", int'(bus.in_ready), 0);
               chk("t2_hold_sr_ce", int'(bus.sr_ce), 0);
            end
            if (last_acc) cnt++;
            guard++;
         end
         if (guard >= 1000) chk("t2_timeout", cnt, 32);
      end
      drain();
      chk("t2_windows", n_win - n0, 12);

      // 4: start of frame arrives with pixel 10
      n0 = n_win;
      run_pix(10, 1'b1, 1'b0, 1'b0);
      run_pix(32, 1'b1, 1'b0, 1'b0);
      drain();
      chk("t4_windows", n_win - n0, 12);

      // 5: reset at pixel 20, pixels without sof, then a clean frame
      run_pix(20, 1'b1, 1'b0, 1'b0);
      do_reset();
      n0 = n_win;
      run_pix(5, 1'b0, 1'b0, 1'b0);
      drain();
      chk("t5_no_sof_windows", n_win - n0, 0);
      run_pix(32, 1'b1, 1'b0, 1'b0);
      drain();
      chk("t5_windows", n_win - n0, 12);

      // 6: gappy input, random consumer
      logsel = 2;
      run_pix(32, 1'b1, 1'b1, 1'b1);
      drain();
      logsel = 0;
      chk("t6_log_len", log_b.size(), log_a.size());
      for (int i = 0; i < log_a.size() && i < log_b.size(); i++) begin
         chk("t6_seq_x", log_b[i].x, log_a[i].x);
         chk("t6_seq_y", log_b[i].y, log_a[i].y);
      end

      // random mix including stray sof pulses
      for (int i = 0; i < 400; i++)
         step(1'($urandom_range(0, 1)), ($urandom_range(0, 39) == 0), 1'($urandom_range(0, 1)));
      drain();
      chk("sb_empty", sb_q.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
